// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg
//   Shared definitions for the chunked multi-cycle arithmetic blocks:
//   the three-state control encoding and helpers that derive the chunk
//   count and the chunk index width from WIDTH/CHUNK.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices that make up a WIDTH-bit operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register width; a single-chunk build still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if
//   Operand/result handshake bundle for seq_chunk_adder.
//   Request side : in_valid/in_ready, a, b, cin, sub
//   Response side: out_valid/out_ready, sum, cout, ovf
//   master = producer of operands / consumer of results, slave = the adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// seq_chunk_adder_chunk_adder
//   Combinational CHUNK-bit ripple-carry adder made of full-adder cells.
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   s     : chunk sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow)
module seq_chunk_adder_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout  = c_s[CHUNK];
  assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle add/subtract: WIDTH-bit operands are processed CHUNK bits
//   per clock through one shared ripple adder, carry kept in a register.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_chunk_adder_if slave (operand handshake in, result handshake out)
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Operands and result are viewed as arrays of chunks so the index selects
  // a slice directly.
  state_e                        state_q, state_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  b_q, b_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  sum_q, sum_d;
  logic                          carry_q, carry_d;
  logic                          cout_q, cout_d;
  logic                          ovf_q, ovf_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;

  logic [CHUNK-1:0]              chunk_sum_s;
  logic                          chunk_cout_s;
  logic                          chunk_cmsb_s;

  seq_chunk_adder_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .s     (chunk_sum_s),
    .cout  (chunk_cout_s),
    .c_msb (chunk_cmsb_s)
  );

  // Next-state, datapath updates and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = chunk_sum_s;
        carry_d      = chunk_cout_s;
        if (idx_q == IDX_LAST) begin
          cout_d  = chunk_cout_s;
          ovf_d   = chunk_cmsb_s ^ chunk_cout_s;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: four instances (CHUNK = 4, 1, 8, 32) share one
// stimulus stream; each has its own scoreboard queue and latency check.
module tb_seq_chunk_adder;

  localparam int W  = 32;
  localparam int NI = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  function automatic int chunk_sel(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] t;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
    return r;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        cin_s;
  logic        sub_s;
  logic        out_ready_s;
  res_t        exp_s;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CH  = chunk_sel(g);
    localparam int NCH = W / CH;

    seq_chunk_adder_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid_s;
    assign bus.a         = a_s;
    assign bus.b         = b_s;
    assign bus.cin       = cin_s;
    assign bus.sub       = sub_s;
    assign bus.out_ready = out_ready_s;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    res_t exp_q[$];
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;
    logic rst_chk = 1'b0;

    // Monitor: reset values, acceptance push, latency, stability and results.
    always @(negedge clk) begin
      if (rst_chk) begin
        chk($sformatf("c%0d_rst_in_ready", CH), bus.in_ready, 1);
        chk($sformatf("c%0d_rst_out_valid", CH), bus.out_valid, 0);
        chk($sformatf("c%0d_rst_sum", CH), bus.sum, 0);
        chk($sformatf("c%0d_rst_cout", CH), bus.cout, 0);
        chk($sformatf("c%0d_rst_ovf", CH), bus.ovf, 0);
      end
      if (rst) begin
        exp_q.delete();
        ov_prev <= 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(exp_s);
          acc_cyc <= cyc + 1;
        end
        if (bus.out_valid) begin
          if (!ov_prev) chk($sformatf("c%0d_latency", CH), cyc - acc_cyc, NCH);
          chk($sformatf("c%0d_in_ready_busy", CH), bus.in_ready, 0);
          if (exp_q.size() == 0) begin
            chk($sformatf("c%0d_unexpected_out", CH), 1, 0);
          end else begin
            chk($sformatf("c%0d_sum", CH), bus.sum, exp_q[0].sum);
            chk($sformatf("c%0d_cout", CH), bus.cout, exp_q[0].cout);
            chk($sformatf("c%0d_ovf", CH), bus.ovf, exp_q[0].ovf);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        ov_prev <= bus.out_valid;
      end
      rst_chk <= rst;
    end
  end

  wire all_ready = g_dut[0].bus.in_ready & g_dut[1].bus.in_ready &
                   g_dut[2].bus.in_ready & g_dut[3].bus.in_ready;
  wire all_valid = g_dut[0].bus.out_valid & g_dut[1].bus.out_valid &
                   g_dut[2].bus.out_valid & g_dut[3].bus.out_valid;

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!all_ready && n < 400);
    if (!all_ready) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic send(input vec_t v);
    wait_idle();
    a_s        = v.a;
    b_s        = v.b;
    cin_s      = v.cin;
    sub_s      = v.sub;
    exp_s      = v.exp;
    in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
  endtask

  task automatic check_pending(input int n);
    chk("pending_c4",  g_dut[0].exp_q.size(), n);
    chk("pending_c1",  g_dut[1].exp_q.size(), n);
    chk("pending_c8",  g_dut[2].exp_q.size(), n);
    chk("pending_c32", g_dut[3].exp_q.size(), n);
  endtask

  vec_t vec[13];
  vec_t v;

  initial begin
    rst         = 1'b1;
    in_valid_s  = 1'b0;
    a_s         = 32'd0;
    b_s         = 32'd0;
    cin_s       = 1'b0;
    sub_s       = 1'b0;
    out_ready_s = 1'b1;
    exp_s       = '0;

    //          a              b              cin   sub     sum            cout  ovf
    vec[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0}};
    vec[1]  = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, '{32'h00000010, 1'b0, 1'b0}};
    vec[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1}};
    vec[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0}};
    vec[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1}};
    vec[5]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0}};
    vec[6]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, '{32'h00000000, 1'b0, 1'b0}};
    vec[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, '{32'hFFFFFFFF, 1'b1, 1'b0}};
    vec[8]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0}};
    vec[9]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, '{32'hFFFFFFFF, 1'b0, 1'b0}};
    vec[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1}};
    vec[11] = '{32'h0000000A, 32'h00000003, 1'b0, 1'b1, '{32'h00000007, 1'b1, 1'b0}};
    vec[12] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1}};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) send(vec[i]);

    // Backpressure: result held in DONE while a new request is presented.
    wait_idle();
    out_ready_s = 1'b0;
    send('{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00010000, 1'b0, 1'b0}});
    for (int n = 0; n < 400 && !all_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_all_done", all_valid, 1);
    a_s        = 32'h00000100;
    b_s        = 32'h00000001;
    cin_s      = 1'b0;
    sub_s      = 1'b1;
    exp_s      = '{32'h000000FF, 1'b1, 1'b0};
    in_valid_s = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    check_pending(1);

    // Reset while the 4-bit instance works on chunk 3 (32-bit one sits in DONE).
    wait_idle();
    out_ready_s = 1'b0;
    send('{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0}});
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready_s = 1'b1;
    check_pending(0);
    send(vec[5]);

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      v.a   = $urandom;
      v.b   = $urandom;
      v.cin = 1'($urandom_range(0, 1));
      v.sub = 1'($urandom_range(0, 1));
      v.exp = model(v.a, v.b, v.cin, v.sub);
      send(v);
    end

    wait_idle();
    check_pending(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
